plot_sink: RTL and testbench

PLOT_SINK -- requirements
Module: plot_sink

---
 rtl/plot_sink_pkg.sv | 36 +++
 rtl/plot_sink_fb_ram.sv | 32 +++
 rtl/plot_sink.sv | 215 +++++++++++++++++++++
 tb/tb_plot_sink.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/plot_sink_pkg.sv
// plot_sink_pkg: shared constants, types and helpers for the plot sink.
//   FB_WIDTH/FB_HEIGHT : framebuffer geometry (160 x 120)
//   FB_DEPTH           : number of framebuffer words (19200)
//   ADDR_W / COLOUR_W  : framebuffer address and pixel widths
//   state_t            : top-level control states
//   pix_t              : one queued pixel (framebuffer address + colour)
package plot_sink_pkg;

   localparam int FB_WIDTH  = 160;
   localparam int FB_HEIGHT = 120;
   localparam int FB_DEPTH  = 19200;
   localparam int ADDR_W    = 15;
   localparam int COLOUR_W  = 3;

   // Address of pixel (159,119); the last word of the framebuffer.
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]   addr;
      logic [COLOUR_W-1:0] colour;
   } pix_t;

   // y*160 + x without a multiplier: y*128 + y*32 + x.
   function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] x,
                                                 input logic [6:0] y);
      logic [ADDR_W-1:0] yy;
      yy = {8'd0, y};
      return (yy << 7) + (yy << 5) + {7'd0, x};
   endfunction

endpackage

// File: rtl/plot_sink_fb_ram.sv
// fb_ram: single-port framebuffer, FB_DEPTH x COLOUR_W.
//   clk   : clock
//   en    : access enable (one access per cycle)
//   we    : 1 = write wdata to addr, 0 = read addr
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, valid the cycle after a read access
// Contents are not reset.
module fb_ram
   import plot_sink_pkg::*;
(
   input  logic                clk,
   input  logic                en,
   input  logic                we,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [COLOUR_W-1:0] wdata,
   output logic [COLOUR_W-1:0] rdata
);

   logic [COLOUR_W-1:0] mem [FB_DEPTH];
   logic [COLOUR_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[addr] <= wdata;
         else    rdata_q   <= mem[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/plot_sink.sv
// plot_sink: pixel plot sink with a queued write path into a 160x120x3
// framebuffer, a clear engine and a readback port.
//   clk, rstn                 : clock, async active-low reset
//   vga_x/vga_y/vga_colour    : plot coordinate and colour
//   vga_plot                  : plot strobe, one pixel per cycle, no backpressure
//   clear / busy              : start a framebuffer clear / clear in progress
//   rd_req/rd_x/rd_y          : readback request
//   rd_ready                  : readback accepted this cycle
//   rd_valid/rd_colour        : readback response, one cycle after acceptance
//   plot_count                : pixels written since clear/reset (saturating)
//   frame_done/overflow/oob   : sticky status flags
//   checksum                  : sum of written colours (only with FB_CHECKSUM_EN)
// Optional feature macro: FB_CHECKSUM_EN.
module plot_sink
   import plot_sink_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
)(
   input  logic                clk,
   input  logic                rstn,
   input  logic [7:0]          vga_x,
   input  logic [6:0]          vga_y,
   input  logic [COLOUR_W-1:0] vga_colour,
   input  logic                vga_plot,
   input  logic                clear,
   output logic                busy,
   input  logic                rd_req,
   input  logic [7:0]          rd_x,
   input  logic [6:0]          rd_y,
   output logic                rd_ready,
   output logic                rd_valid,
   output logic [COLOUR_W-1:0] rd_colour,
   output logic [14:0]         plot_count,
   output logic                frame_done,
   output logic                overflow,
`ifdef FB_CHECKSUM_EN
   output logic [15:0]         checksum,
`endif
   output logic                oob
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
   logic [PTR_W-1:0]    wp_q, wp_d, rp_q, rp_d;
   logic [PTR_W:0]      cnt_q, cnt_d;
   logic [14:0]         plot_count_q, plot_count_d;
   logic                frame_done_q, frame_done_d;
   logic                overflow_q, overflow_d;
   logic                oob_q, oob_d;
   logic                rd_valid_q, rd_valid_d;
`ifdef FB_CHECKSUM_EN
   logic [15:0]         checksum_q, checksum_d;
`endif
   pix_t                fifo_q [FIFO_DEPTH];

   logic                idle, in_range, rd_accept, in_ok, mem_free;
   logic                empty, full, wr_en, pop_fifo, store;
   pix_t                in_pix, wr_pix;

   logic                ram_en, ram_we;
   logic [ADDR_W-1:0]   ram_addr;
   logic [COLOUR_W-1:0] ram_wdata, ram_rdata;

   assign idle      = (state_q == ST_IDLE);
   assign in_range  = (vga_x < 8'(FB_WIDTH)) && (vga_y < 7'(FB_HEIGHT));
   assign rd_ready  = idle && !clear;
   assign rd_accept = rd_ready && rd_req;
   assign in_ok     = rd_ready && vga_plot && in_range;
   assign mem_free  = rd_ready && !rd_req;
   assign empty     = (cnt_q == '0);
   assign full      = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
   assign in_pix    = '{addr: fb_addr(vga_x, vga_y), colour: vga_colour};

   // Fall-through queue: an empty queue lets the incoming pixel go straight
   // to memory, so a stalled write port can absorb FIFO_DEPTH pixels before
   // anything is dropped.
   assign wr_pix    = empty ? in_pix : fifo_q[rp_q];
   assign wr_en     = mem_free && (!empty || in_ok);
   assign pop_fifo  = wr_en && !empty;
   assign store     = in_ok && !(empty && mem_free) && (!full || pop_fifo);

   always_comb begin
      state_d      = state_q;
      clr_addr_d   = clr_addr_q;
      wp_d         = wp_q;
      rp_d         = rp_q;
      cnt_d        = cnt_q;
      plot_count_d = plot_count_q;
      frame_done_d = frame_done_q;
      overflow_d   = overflow_q;
      oob_d        = oob_q;
      rd_valid_d   = rd_accept;
`ifdef FB_CHECKSUM_EN
      checksum_d   = checksum_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (clear) begin
               state_d      = ST_CLEAR;
               clr_addr_d   = '0;
               wp_d         = '0;
               rp_d         = '0;
               cnt_d        = '0;
               plot_count_d = '0;
               frame_done_d = 1'b0;
               overflow_d   = 1'b0;
               oob_d        = 1'b0;
`ifdef FB_CHECKSUM_EN
               checksum_d   = '0;
`endif
            end else begin
               if (pop_fifo) rp_d = rp_q + PTR_W'(1);
               if (store)    wp_d = wp_q + PTR_W'(1);
               if (store && !pop_fifo)      cnt_d = cnt_q + (PTR_W+1)'(1);
               else if (!store && pop_fifo) cnt_d = cnt_q - (PTR_W+1)'(1);
               if (in_ok && full && !pop_fifo)      overflow_d = 1'b1;
               if (vga_plot && !in_range)           oob_d      = 1'b1;
               if (wr_en) begin
                  if (plot_count_q != 15'h7fff) plot_count_d = plot_count_q + 15'd1;
                  if (wr_pix.addr == LAST_ADDR)   frame_done_d = 1'b1;
`ifdef FB_CHECKSUM_EN
                  checksum_d = checksum_q + {13'd0, wr_pix.colour};
`endif
               end
            end
         end
         ST_CLEAR: begin
            clr_addr_d = clr_addr_q + ADDR_W'(1);
            if (clr_addr_q == LAST_ADDR) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Single memory port: clear owns it in CLEAR; in IDLE a read beats a write.
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (!idle) begin
         ram_en   = 1'b1;
         ram_we   = 1'b1;
         ram_addr = clr_addr_q;
      end else if (rd_accept) begin
         ram_en   = 1'b1;
         ram_addr = fb_addr(rd_x, rd_y);
      end else if (wr_en) begin
         ram_en    = 1'b1;
         ram_we    = 1'b1;
         ram_addr  = wr_pix.addr;
         ram_wdata = wr_pix.colour;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         clr_addr_q   <= '0;
         wp_q         <= '0;
         rp_q         <= '0;
         cnt_q        <= '0;
         plot_count_q <= '0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         oob_q        <= 1'b0;
         rd_valid_q   <= 1'b0;
`ifdef FB_CHECKSUM_EN
         checksum_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         clr_addr_q   <= clr_addr_d;
         wp_q         <= wp_d;
         rp_q         <= rp_d;
         cnt_q        <= cnt_d;
         plot_count_q <= plot_count_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
         oob_q        <= oob_d;
         rd_valid_q   <= rd_valid_d;
`ifdef FB_CHECKSUM_EN
         checksum_q   <= checksum_d;
`endif
      end
   end

   // Queue storage needs no reset; occupancy is tracked by cnt_q.
   always_ff @(posedge clk) begin
      if (store) fifo_q[wp_q] <= in_pix;
   end

   fb_ram u_fb_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   assign busy       = !idle;
   assign rd_valid   = rd_valid_q;
   assign rd_colour  = rd_valid_q ? ram_rdata : '0;
   assign plot_count = plot_count_q;
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;
   assign oob        = oob_q;
`ifdef FB_CHECKSUM_EN
   assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_plot_sink.sv
// tb_plot_sink: self-checking bench for plot_sink. Readbacks push their
// expected colour and due cycle into a scoreboard; a monitor pops and
// compares on every rd_valid.
module tb_plot_sink;
   import plot_sink_pkg::*;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [7:0]  vga_x = '0;
   logic [6:0]  vga_y = '0;
   logic [2:0]  vga_colour = '0;
   logic        vga_plot = 1'b0;
   logic        clear = 1'b0;
   logic        busy;
   logic        rd_req = 1'b0;
   logic [7:0]  rd_x = '0;
   logic [6:0]  rd_y = '0;
   logic        rd_ready, rd_valid;
   logic [2:0]  rd_colour;
   logic [14:0] plot_count;
   logic        frame_done, overflow, oob;
`ifdef FB_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   plot_sink #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .rstn(rstn),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
      .clear(clear), .busy(busy),
      .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_ready(rd_ready),
      .rd_valid(rd_valid), .rd_colour(rd_colour),
      .plot_count(plot_count), .frame_done(frame_done), .overflow(overflow),
`ifdef FB_CHECKSUM_EN
      .checksum(checksum),
`endif
      .oob(oob)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_bad = 0;

   typedef struct {
      logic [2:0]  col;
      int unsigned due;
   } exp_t;
   exp_t sb[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rstn && rd_valid) begin
         exp_t e;
         if (sb.size() == 0) chk("rd_unexpected", 32'(rd_valid), 32'd0);
         else begin
            e = sb.pop_front();
            chk("rd_latency", cyc, e.due);
            chk("rd_colour", 32'(rd_colour), 32'(e.col));
         end
      end
   end

   task automatic do_read(input int x, input int y, input logic [2:0] col);
      @(negedge clk);
      rd_req = 1'b1; rd_x = 8'(x); rd_y = 7'(y);
      sb.push_back('{col: col, due: cyc + 1});
      @(negedge clk);
      rd_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_clear();
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
   endtask

   // Counts busy cycles after a clear pulse; optionally re-pulses clear.
   task automatic wait_busy(input int repulse_at, output int n);
      n = 0;
      while (busy && n < 20000) begin
         clear = (n == repulse_at);
         @(negedge clk);
         n++;
      end
      clear = 1'b0;
   endtask

   // Full raster, colour x%8, with a readback of (13,7) held for hold_len cycles.
   task automatic stream(input int hold_at, input int hold_len);
      for (int i = 0; i < FB_DEPTH; i++) begin
         @(negedge clk);
         vga_plot   = 1'b1;
         vga_x      = 8'(i % FB_WIDTH);
         vga_y      = 7'(i / FB_WIDTH);
         vga_colour = 3'((i % FB_WIDTH) % 8);
         rd_req     = (i >= hold_at) && (i < hold_at + hold_len);
         if (rd_req) begin
            rd_x = 8'd13; rd_y = 7'd7;
            sb.push_back('{col: 3'd5, due: cyc + 1});
         end
      end
      @(negedge clk);
      vga_plot = 1'b0; rd_req = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   int n;

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_plot_count", 32'(plot_count), 0);
      chk("rst_flags", {29'd0, frame_done, overflow, oob}, 0);
      rstn = 1'b1;
      @(negedge clk);
      chk("idle_rd_ready", 32'(rd_ready), 1);

      // plain clear and readback of a cleared pixel
      pulse_clear();
      wait_busy(-1, n);
      chk("clear_len", n, 19200);
      do_read(5, 5, 3'd0);

      // full raster with a 4-cycle read stall: nothing lost
      stream(3000, 4);
      chk("s1_plot_count", 32'(plot_count), 19200);
      chk("s1_frame_done", 32'(frame_done), 1);
      chk("s1_overflow", 32'(overflow), 0);
      chk("s1_oob", 32'(oob), 0);
`ifdef FB_CHECKSUM_EN
      chk("s1_checksum", 32'(checksum), 1664);
`endif
      do_read(13, 7, 3'd5);
      do_read(159, 119, 3'd7);
      do_read(8, 60, 3'd0);

      // fresh counters via reset, then a 5-cycle stall: one pixel dropped
      @(negedge clk); rstn = 1'b0;
      @(negedge clk); rstn = 1'b1;
      chk("rst2_plot_count", 32'(plot_count), 0);
      stream(3000, 5);
      chk("s2_overflow", 32'(overflow), 1);
      chk("s2_plot_count", 32'(plot_count), 19199);
      chk("s2_frame_done", 32'(frame_done), 1);

      // out-of-range plots
      @(negedge clk); vga_plot = 1'b1; vga_x = 8'd160; vga_y = 7'd0;
      @(negedge clk); vga_x = 8'd0; vga_y = 7'd120;
      @(negedge clk); vga_plot = 1'b0;
      repeat (3) @(negedge clk);
      chk("oob_flag", 32'(oob), 1);
      chk("oob_plot_count", 32'(plot_count), 19199);

      // reset in the middle of a clear
      pulse_clear();
      repeat (100) @(negedge clk);
      chk("midclr_busy", 32'(busy), 1);
      rstn = 1'b0;
      #1;
      chk("midclr_rst_busy", 32'(busy), 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("midclr_rd_ready", 32'(rd_ready), 1);
      chk("midclr_busy_after", 32'(busy), 0);

      // clear wins over a same-cycle read; re-pulse mid-clear is ignored
      @(negedge clk);
      clear = 1'b1; rd_req = 1'b1; rd_x = 8'd13; rd_y = 7'd7;
      #1;
      chk("clr_vs_rd_ready", 32'(rd_ready), 0);
      @(negedge clk);
      clear = 1'b0; rd_req = 1'b0;
      wait_busy(50, n);
      chk("repulse_len", n, 19200);
      do_read(13, 7, 3'd0);

      repeat (3) @(negedge clk);
      chk("sb_left", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
